// File: rtl/load_unit_fsm.sv
// Multi-cycle load unit: takes one load per handshake, reads the aligned word from a
// req/gnt + rvalid memory, then extracts, extends or merges it. A bus timeout is included.
module load_unit_fsm #(
  parameter int unsigned ADDR_W     = 32,
  parameter bit          BIG_ENDIAN = 1'b0,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_rt,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_data,
  output logic              rsp_adel,
  output logic              rsp_err,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;
  typedef enum logic [2:0] {
    OP_LW, OP_LBU, OP_LB, OP_LHU, OP_LH, OP_LWL, OP_LWR, OP_ILL
  } op_t;

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t           state;
  op_t              op_q;
  logic [1:0]       lane_q;
  logic [31:0]      rt_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             expired;
  logic             misaligned;
  logic [1:0]       req_lane;

  // A big-endian lane is 3-A, which for two bits is simply the bitwise inverse.
  assign req_lane = BIG_ENDIAN ? ~req_addr[1:0] : req_addr[1:0];
  assign cnt_nxt  = cnt + 1'b1;
  assign expired  = (TIMEOUT != 0) && (cnt_nxt == CNT_W'(TIMEOUT));

  always_comb begin
    // NOTE: default first so every path assigns it and no latch is inferred.
    misaligned = 1'b0;
    case (op_t'(req_op))
      OP_LW:         misaligned = |req_addr[1:0];
      OP_LH, OP_LHU: misaligned = req_addr[0];
      OP_ILL:        misaligned = 1'b1;
      default:       misaligned = 1'b0;
    endcase
  end

  function automatic logic [31:0] load_result(input op_t op, input logic [1:0] lane,
                                              input logic [31:0] m, input logic [31:0] rt);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = m[{lane, 3'b000} +: 8];
    h = m[{lane[1], 4'b0000} +: 16];
    r = m;
    case (op)
      OP_LBU: r = {24'h0, b};
      OP_LB:  r = {{24{b[7]}}, b};
      OP_LHU: r = {16'h0, h};
      OP_LH:  r = {{16{h[15]}}, h};
      OP_LWL:
        case (lane)
          2'd0:    r = {m[7:0], rt[23:0]};
          2'd1:    r = {m[15:0], rt[15:0]};
          2'd2:    r = {m[23:0], rt[7:0]};
          default: r = m;
        endcase
      OP_LWR:
        case (lane)
          2'd0:    r = m;
          2'd1:    r = {rt[31:24], m[31:8]};
          2'd2:    r = {rt[31:16], m[31:16]};
          default: r = {rt[31:8], m[31:24]};
        endcase
      default: r = m;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      op_q      <= OP_LW;
      lane_q    <= 2'd0;
      rt_q      <= 32'h0;
      cnt       <= '0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= 32'h0;
      rsp_adel  <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout so every register sees pre-edge values.
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE:
          if (req_valid) begin
            op_q      <= op_t'(req_op);
            lane_q    <= req_lane;
            rt_q      <= req_rt;
            cnt       <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (misaligned) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_adel  <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_data  <= 32'h0;
            end else begin
              state    <= S_REQ;
              mem_req  <= 1'b1;
              mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
            end
          end
        S_REQ: begin
          cnt <= cnt_nxt;
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= S_WAIT;
          end else if (expired) begin
            mem_req   <= 1'b0;
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_adel  <= 1'b0;
            rsp_err   <= 1'b1;
            rsp_data  <= 32'h0;
          end
        end
        S_WAIT: begin
          cnt <= cnt_nxt;
          // Data arriving on the expiry cycle still completes the load normally.
          if (mem_rvalid) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_adel  <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= load_result(op_q, lane_q, mem_rdata, rt_q);
          end else if (expired) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_adel  <= 1'b0;
            rsp_err   <= 1'b1;
            rsp_data  <= 32'h0;
          end
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_unit_fsm.sv
// Directed bench for load_unit_fsm: a little-endian and a big-endian instance (TIMEOUT=4)
// share all stimulus; the expected values are computed by hand.
module tb_load_unit_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_rt = 32'h0;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  logic        req_ready0, mem_req0, rsp_valid0, rsp_adel0, rsp_err0, busy0;
  logic [31:0] mem_addr0, rsp_data0;
  logic        req_ready1, mem_req1, rsp_valid1, rsp_adel1, rsp_err1, busy1;
  logic [31:0] mem_addr1, rsp_data1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  load_unit_fsm #(.ADDR_W(32), .BIG_ENDIAN(1'b0), .TIMEOUT(4)) dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready0),
    .req_op(req_op), .req_addr(req_addr), .req_rt(req_rt),
    .mem_req(mem_req0), .mem_addr(mem_addr0), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid0), .rsp_data(rsp_data0), .rsp_adel(rsp_adel0),
    .rsp_err(rsp_err0), .busy(busy0)
  );

  load_unit_fsm #(.ADDR_W(32), .BIG_ENDIAN(1'b1), .TIMEOUT(4)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready1),
    .req_op(req_op), .req_addr(req_addr), .req_rt(req_rt),
    .mem_req(mem_req1), .mem_addr(mem_addr1), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid1), .rsp_data(rsp_data1), .rsp_adel(rsp_adel1),
    .rsp_err(rsp_err1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one load and plays memory: grant after gd REQ cycles, rvalid after rd WAIT
  // cycles (rd<0: never). lat = cycles from the accepting edge to the rsp_valid cycle.
  task automatic do_load(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] rt,
                         input int gd, input int rd, input logic [31:0] rdata,
                         output int lat, output bit saw_req, output logic [31:0] maddr);
    bit granted = 1'b0;
    bit rv_en   = (rd >= 0);
    int gcnt    = 0;
    int rcnt    = 0;
    lat = -1;
    saw_req = 1'b0;
    maddr = 32'h0;
    req_valid = 1'b1;
    req_op = op;
    req_addr = addr;
    req_rt = rt;
    step();
    req_valid = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      if (rsp_valid0) begin
        lat = cyc;
        break;
      end
      if (mem_req0) begin
        saw_req = 1'b1;
        maddr = mem_addr0;
      end
      if (mem_req0 && !granted) begin
        if (gcnt == gd) begin
          mem_gnt = 1'b1;
          granted = 1'b1;
        end
        gcnt++;
      end else if (granted && rv_en) begin
        if (rcnt == rd) begin
          mem_rvalid = 1'b1;
          mem_rdata = rdata;
          rv_en = 1'b0;
        end
        rcnt++;
      end
      step();
    end
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    step();
    check("strobe_one_cycle", {31'h0, rsp_valid0}, 32'h0);
    check("ready_after_rsp", {31'h0, req_ready0}, 32'h1);
  endtask

  task automatic t_load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] rt, input int gd, input int rd,
                        input logic [31:0] rdata, input int exp_lat,
                        input logic [31:0] exp_le, input logic [31:0] exp_be,
                        input bit exp_adel, input bit exp_err, input bit exp_req,
                        input logic [31:0] exp_maddr);
    int          lat;
    bit          saw_req;
    logic [31:0] maddr;
    do_load(op, addr, rt, gd, rd, rdata, lat, saw_req, maddr);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_data_le"}, rsp_data0, exp_le);
    check({tag, "_data_be"}, rsp_data1, exp_be);
    check({tag, "_adel"}, {31'h0, rsp_adel0}, {31'h0, exp_adel});
    check({tag, "_err"}, {31'h0, rsp_err0}, {31'h0, exp_err});
    check({tag, "_memreq"}, {31'h0, saw_req}, {31'h0, exp_req});
    check({tag, "_memaddr"}, maddr, exp_maddr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    #23;
    check("rst_ready", {31'h0, req_ready0}, 32'h1);
    check("rst_busy", {31'h0, busy0}, 32'h0);
    check("rst_memreq", {31'h0, mem_req0}, 32'h0);
    check("rst_memaddr", mem_addr0, 32'h0);
    check("rst_rspvalid", {31'h0, rsp_valid0}, 32'h0);
    check("rst_rspdata", rsp_data0, 32'h0);
    check("rst_flags", {30'h0, rsp_adel0, rsp_err0}, 32'h0);
    reset = 1'b0;
    step();

    //     tag        op    addr         rt            gd  rd  rdata         lat  LE data       BE data      adel err req maddr
    t_load("lb_neg",  3'd2, 32'h103, 32'h0,         0,  0, 32'h80FF_1234, 3, 32'hFFFF_FF80, 32'h0000_0034, 0, 0, 1, 32'h100);
    t_load("lhu",     3'd3, 32'h102, 32'h0,         0,  0, 32'h8001_7FFF, 3, 32'h0000_8001, 32'h0000_7FFF, 0, 0, 1, 32'h100);
    t_load("lh_mis",  3'd4, 32'h101, 32'h0,         0,  0, 32'h0,         1, 32'h0,         32'h0,         1, 0, 0, 32'h0);
    t_load("lwl_a1",  3'd5, 32'h101, 32'hAABB_CCDD, 0,  0, 32'h1122_3344, 3, 32'h3344_CCDD, 32'h2233_44DD, 0, 0, 1, 32'h100);
    t_load("lwr_a1",  3'd6, 32'h101, 32'hAABB_CCDD, 0,  0, 32'h1122_3344, 3, 32'hAA11_2233, 32'hAABB_1122, 0, 0, 1, 32'h100);
    t_load("lwl_a3",  3'd5, 32'h103, 32'hAABB_CCDD, 0,  0, 32'h1122_3344, 3, 32'h1122_3344, 32'h44BB_CCDD, 0, 0, 1, 32'h100);
    t_load("lwr_a0",  3'd6, 32'h100, 32'hAABB_CCDD, 0,  0, 32'h1122_3344, 3, 32'h1122_3344, 32'hAABB_CC11, 0, 0, 1, 32'h100);
    // rvalid lands on the fourth REQ/WAIT cycle, the same cycle the timeout expires.
    t_load("lw_slow", 3'd0, 32'h200, 32'h0,         1,  1, 32'hDEAD_BEEF, 5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0, 1, 32'h200);
    t_load("lw_mis",  3'd0, 32'h202, 32'h0,         0,  0, 32'h0,         1, 32'h0,         32'h0,         1, 0, 0, 32'h0);
    t_load("op_ill",  3'd7, 32'h100, 32'h0,         0,  0, 32'h0,         1, 32'h0,         32'h0,         1, 0, 0, 32'h0);
    t_load("lb_pos",  3'd2, 32'h101, 32'h0,         0,  0, 32'h0000_7F00, 3, 32'h0000_007F, 32'h0000_0000, 0, 0, 1, 32'h100);
    t_load("lbu",     3'd1, 32'h103, 32'h0,         0,  0, 32'h80FF_1234, 3, 32'h0000_0080, 32'h0000_0034, 0, 0, 1, 32'h100);
    t_load("lh_neg",  3'd4, 32'h102, 32'h0,         0,  0, 32'h8001_7FFF, 3, 32'hFFFF_8001, 32'h0000_7FFF, 0, 0, 1, 32'h100);
    // Four REQ/WAIT cycles with no data, so the error strobe appears in the fifth cycle.
    t_load("timeout", 3'd0, 32'h300, 32'h0,         0, -1, 32'h0,         5, 32'h0,         32'h0,         0, 1, 1, 32'h300);

    // Reset while WAITing, then a stale rvalid: no response may appear.
    req_valid = 1'b1;
    req_op = 3'd0;
    req_addr = 32'h400;
    step();
    req_valid = 1'b0;
    check("mid_req", {31'h0, mem_req0}, 32'h1);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    check("mid_wait_busy", {31'h0, busy0}, 32'h1);
    reset = 1'b1;
    #2;
    check("mid_rst_ready", {31'h0, req_ready0}, 32'h1);
    check("mid_rst_busy", {31'h0, busy0}, 32'h0);
    reset = 1'b0;
    step();
    mem_rvalid = 1'b1;
    mem_rdata = 32'h1234_5678;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      mem_rvalid = 1'b0;
      seen |= rsp_valid0 | mem_req0;
    end
    check("late_rvalid_ignored", {31'h0, seen}, 32'h0);
    check("post_rst_ready", {31'h0, req_ready0}, 32'h1);
    check("post_rst_data", rsp_data0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
